spi_reg_bridge: RTL and testbench

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge.sv | 114 +++++++++++
 tb/tb_spi_reg_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// SPI byte-stream to register-bus bridge: command byte (R/W + 7-bit address), then data bytes.
// Define SPI_REG_BRIDGE_AUTOINC_EN to advance the address after every write and read fetch.
module spi_reg_bridge #(
   parameter logic [7:0] FILL_BYTE = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs_n,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic [7:0] tx_byte,
   output logic [6:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CMD      = 3'd1,
      WRITE    = 3'd2,
      RD_FETCH = 3'd3,
      READ     = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] cs_sync;
   logic [1:0] live;
   logic       armed;
   logic       cs_s;
   logic [6:0] addr_q, addr_d, next_addr;
   logic [7:0] tx_q;
   logic [7:0] wdata_q;
   logic       we_q, wr_d;
   logic       rd_pend;

   assign cs_s = cs_sync[1];

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
   assign next_addr = addr_q + 7'd1;
`else
   assign next_addr = addr_q;
`endif

   // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte is
   // taken only in CMD, WRITE or READ while synchronised cs_n is low.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wr_d    = 1'b0;
      if (cs_s) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (armed) state_d = CMD;
            CMD: begin
               if (rx_valid) begin
                  addr_d  = rx_byte[6:0];
                  state_d = rx_byte[7] ? RD_FETCH : WRITE;
               end
            end
            WRITE: begin
               if (we_q)     addr_d = next_addr;
               if (rx_valid) wr_d   = 1'b1;
            end
            RD_FETCH: begin
               addr_d  = next_addr;
               state_d = READ;
            end
            READ: if (rx_valid) state_d = RD_FETCH;
            default: state_d = IDLE;
         endcase
      end
   end

   // armed only sets once cs_n has really been sampled high after reset, so a
   // chip select held low through reset cannot start a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cs_sync <= 2'b11;
         live    <= 2'b00;
         armed   <= 1'b0;
         addr_q  <= 7'd0;
         tx_q    <= FILL_BYTE;
         wdata_q <= 8'd0;
         we_q    <= 1'b0;
         rd_pend <= 1'b0;
      end else begin
         state_q <= state_d;
         cs_sync <= {cs_sync[0], cs_n};
         live    <= {live[0], 1'b1};
         armed   <= armed | (live[1] & cs_s);
         addr_q  <= addr_d;
         we_q    <= wr_d;
         if (wr_d) wdata_q <= rx_byte;
         rd_pend <= reg_re;
         if (cs_s)         tx_q <= FILL_BYTE;
         else if (rd_pend) tx_q <= reg_rdata;
      end
   end

   assign tx_byte   = tx_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_we    = we_q;
   assign reg_re    = (state_q == RD_FETCH) && !cs_s;
   assign busy      = ~cs_s;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: write/read frames, wrap, abort, coincident cs rise, reset.
// Expected addresses follow SPI_REG_BRIDGE_AUTOINC_EN when defined.
module tb_spi_reg_bridge;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs_n = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_byte;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata = 8'h00;
   logic       busy;
   logic [2:0] dbg_state;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int both_cnt = 0;
   logic [14:0] wr_q[$];
   logic [6:0]  re_q[$];

   spi_reg_bridge #(.FILL_BYTE(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .tx_byte(tx_byte), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // register model: data[n] = n + 0x40, one cycle after reg_re
   always @(posedge clk) if (reg_re) reg_rdata <= {1'b0, reg_addr} + 8'h40;

   always @(negedge clk) begin
      if (reg_we) wr_q.push_back({reg_addr, reg_wdata});
      if (reg_re) re_q.push_back(reg_addr);
      if (reg_we && reg_re) both_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [14:0] pop_wr();
      if (wr_q.size() == 0) return 15'bx;
      return wr_q.pop_front();
   endfunction

   function automatic logic [6:0] pop_re();
      if (re_q.size() == 0) return 7'bx;
      return re_q.pop_front();
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic start_frame();
      @(negedge clk);
      cs_n = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic end_frame();
      @(negedge clk);
      cs_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (tx_byte !== 8'hFF) $display("FAIL rst_tx got %h exp ff", tx_byte); else n_pass++;
      n_checks++; if (reg_addr !== 7'd0) $display("FAIL rst_addr got %h exp 00", reg_addr); else n_pass++;
      n_checks++; if (reg_wdata !== 8'd0) $display("FAIL rst_wdata got %h exp 00", reg_wdata); else n_pass++;
      n_checks++; if ({reg_we, reg_re, busy} !== 3'b000) $display("FAIL rst_strobes got %b exp 000", {reg_we, reg_re, busy}); else n_pass++;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (dbg_state !== 3'd0) $display("FAIL rst_state got %0d exp 0", dbg_state); else n_pass++;
   endtask

   task automatic test_write();
      logic [14:0] w;
      wr_q.delete(); re_q.delete();
      start_frame();
      n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy got %b exp 1", busy); else n_pass++;
      send_byte(8'h05);
      n_checks++; if (dbg_state !== 3'd2) $display("FAIL wr_state got %0d exp 2", dbg_state); else n_pass++;
      send_byte(8'hA1);
      send_byte(8'hB2);
      n_checks++; if (tx_byte !== 8'hFF) $display("FAIL wr_tx got %h exp ff", tx_byte); else n_pass++;
      end_frame();
      n_checks++; if (wr_q.size() != 2) $display("FAIL wr_count got %0d exp 2", wr_q.size()); else n_pass++;
      w = pop_wr();
      n_checks++; if (w !== {7'd5, 8'hA1}) $display("FAIL wr_first got %h exp %h", w, {7'd5, 8'hA1}); else n_pass++;
      w = pop_wr();
      n_checks++; if (w !== {AUTOINC ? 7'd6 : 7'd5, 8'hB2}) $display("FAIL wr_second got %h", w); else n_pass++;
      n_checks++; if (re_q.size() != 0) $display("FAIL wr_no_re got %0d exp 0", re_q.size()); else n_pass++;
   endtask

   task automatic test_read();
      logic [6:0] a;
      wr_q.delete(); re_q.delete();
      start_frame();
      n_checks++; if (tx_byte !== 8'hFF) $display("FAIL rd_tx0 got %h exp ff", tx_byte); else n_pass++;
      send_byte(8'h90);
      n_checks++; if (tx_byte !== 8'h50) $display("FAIL rd_tx1 got %h exp 50", tx_byte); else n_pass++;
      send_byte(8'h00);
      n_checks++; if (tx_byte !== (AUTOINC ? 8'h51 : 8'h50)) $display("FAIL rd_tx2 got %h", tx_byte); else n_pass++;
      send_byte(8'h00);
      n_checks++; if (tx_byte !== (AUTOINC ? 8'h52 : 8'h50)) $display("FAIL rd_tx3 got %h", tx_byte); else n_pass++;
      end_frame();
      n_checks++; if (tx_byte !== 8'hFF) $display("FAIL rd_tx_end got %h exp ff", tx_byte); else n_pass++;
      n_checks++; if (re_q.size() != 3) $display("FAIL rd_count got %0d exp 3", re_q.size()); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         a = pop_re();
         n_checks++;
         if (a !== (AUTOINC ? 7'd16 + 7'(i) : 7'd16)) $display("FAIL rd_addr%0d got %0d", i, a);
         else n_pass++;
      end
      n_checks++; if (wr_q.size() != 0) $display("FAIL rd_no_we got %0d exp 0", wr_q.size()); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [14:0] w;
      wr_q.delete(); re_q.delete();
      start_frame();
      send_byte(8'h7F);
      send_byte(8'h11);
      send_byte(8'h22);
      end_frame();
      n_checks++; if (wr_q.size() != 2) $display("FAIL wrap_count got %0d exp 2", wr_q.size()); else n_pass++;
      w = pop_wr();
      n_checks++; if (w !== {7'd127, 8'h11}) $display("FAIL wrap_first got %h", w); else n_pass++;
      w = pop_wr();
      n_checks++; if (w !== {AUTOINC ? 7'd0 : 7'd127, 8'h22}) $display("FAIL wrap_second got %h", w); else n_pass++;
   endtask

   task automatic test_empty_frames();
      logic [6:0] a;
      wr_q.delete(); re_q.delete();
      start_frame(); send_byte(8'h33); end_frame();
      n_checks++; if (wr_q.size() != 0) $display("FAIL empty_wr got %0d exp 0", wr_q.size()); else n_pass++;
      start_frame(); send_byte(8'hA4); end_frame();
      n_checks++; if (re_q.size() != 1) $display("FAIL empty_rd_count got %0d exp 1", re_q.size()); else n_pass++;
      a = pop_re();
      n_checks++; if (a !== 7'h24) $display("FAIL empty_rd_addr got %h exp 24", a); else n_pass++;
   endtask

   task automatic test_abort();
      logic [14:0] w;
      wr_q.delete(); re_q.delete();
      start_frame();
      send_byte(8'h03);
      send_byte(8'hC1);
      end_frame();
      send_byte(8'hC2);
      send_byte(8'hC3);
      n_checks++; if (dbg_state !== 3'd0) $display("FAIL abort_state got %0d exp 0", dbg_state); else n_pass++;
      n_checks++; if (wr_q.size() != 1) $display("FAIL abort_count got %0d exp 1", wr_q.size()); else n_pass++;
      w = pop_wr();
      n_checks++; if (w !== {7'd3, 8'hC1}) $display("FAIL abort_wr got %h", w); else n_pass++;
      start_frame();
      send_byte(8'h20);
      send_byte(8'h5A);
      end_frame();
      w = pop_wr();
      n_checks++; if (w !== {7'd32, 8'h5A}) $display("FAIL abort_next got %h exp %h", w, {7'd32, 8'h5A}); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] cmds [2];
      cmds[0] = 8'h40;
      cmds[1] = 8'hC0;
      for (int k = 0; k < 2; k++) begin
         wr_q.delete(); re_q.delete();
         start_frame();
         send_byte(cmds[k]);
         @(negedge clk);
         cs_n = 1'b1;
         @(negedge clk);
         @(negedge clk);
         rx_byte  = 8'h77;
         rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
         n_checks++; if (dbg_state !== 3'd0) $display("FAIL coinc_state%0d got %0d exp 0", k, dbg_state); else n_pass++;
         n_checks++; if (tx_byte !== 8'hFF) $display("FAIL coinc_tx%0d got %h exp ff", k, tx_byte); else n_pass++;
         repeat (5) @(negedge clk);
         n_checks++; if (wr_q.size() != 0) $display("FAIL coinc_we%0d got %0d exp 0", k, wr_q.size()); else n_pass++;
         n_checks++; if (re_q.size() != k) $display("FAIL coinc_re%0d got %0d exp %0d", k, re_q.size(), k); else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      logic [14:0] w;
      wr_q.delete(); re_q.delete();
      start_frame();
      @(negedge clk);
      rx_byte  = 8'h90;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (tx_byte !== 8'hFF) $display("FAIL mrst_tx got %h exp ff", tx_byte); else n_pass++;
      n_checks++; if ({reg_we, reg_re, busy} !== 3'b000) $display("FAIL mrst_strobes got %b exp 000", {reg_we, reg_re, busy}); else n_pass++;
      n_checks++; if ({reg_addr, reg_wdata} !== 15'd0) $display("FAIL mrst_bus got %h exp 0", {reg_addr, reg_wdata}); else n_pass++;
      n_checks++; if (dbg_state !== 3'd0) $display("FAIL mrst_state got %0d exp 0", dbg_state); else n_pass++;
      repeat (2) @(negedge clk);
      wr_q.delete(); re_q.delete();
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      n_checks++; if (wr_q.size() + re_q.size() != 0) $display("FAIL mrst_quiet got %0d exp 0", wr_q.size() + re_q.size()); else n_pass++;
      n_checks++; if (dbg_state !== 3'd0) $display("FAIL mrst_hold got %0d exp 0", dbg_state); else n_pass++;
      end_frame();
      start_frame();
      send_byte(8'h0A);
      send_byte(8'h3C);
      end_frame();
      w = pop_wr();
      n_checks++; if (w !== {7'd10, 8'h3C}) $display("FAIL mrst_new got %h exp %h", w, {7'd10, 8'h3C}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wrap();
      test_empty_frames();
      test_abort();
      test_back_to_back();
      test_mid_reset();
      n_checks++; if (both_cnt != 0) $display("FAIL we_re_overlap got %0d exp 0", both_cnt); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
